// File: rtl/tstate_sequencer_pkg.sv
// Shared definitions for the T-state sequencer: FSM states, T-state end
// indices and the width of the one-hot T-state vector.
package tstate_sequencer_pkg;

    localparam int T_WIDTH = 12;
    localparam int T_IDX_W = 4;

    typedef logic [T_IDX_W-1:0] t_idx_t;

    localparam t_idx_t T_DEF_END = 4'd3;
    localparam t_idx_t T_ADD_END = 4'd4;
    localparam t_idx_t T_MEM_END = 4'd5;
    localparam t_idx_t T_MUL_END = 4'd10;
    localparam t_idx_t T_DIV_END = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    // One-hot mask with only bit idx set.
    function automatic logic [T_WIDTH-1:0] t_onehot(input t_idx_t idx);
        return T_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/tstate_end_sel.sv
// Maps the decoder's instruction-class flags to the index of the last T-state.
// Used both for the value latched at T3 and for the live last_t path.
module tstate_end_sel
    import tstate_sequencer_pkg::*;
(
    input  logic   add_s,
    input  logic   mul_s,
    input  logic   div_s,
    input  logic   mem_op,
    output t_idx_t end_idx
);

    // Longest instruction class wins when several flags are set.
    always_comb begin
        end_idx = T_DEF_END;
        if (div_s) begin
            end_idx = T_DIV_END;
        end else if (mul_s) begin
            end_idx = T_MUL_END;
        end else if (mem_op) begin
            end_idx = T_MEM_END;
        end else if (add_s) begin
            end_idx = T_ADD_END;
        end
    end

endmodule

// File: rtl/tstate_sequencer.sv
// T-state sequencer: steps a one-hot T-state vector through each instruction,
// ends it at the class-dependent last T-state, counts completed instructions
// and parks in HALTED after an instruction that had hlt set at T3.
module tstate_sequencer
    import tstate_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step,
    input  logic               add_s,
    input  logic               mul_s,
    input  logic               div_s,
    input  logic               mem_op,
    input  logic               hlt,
    output logic [T_WIDTH-1:0] t,
    output logic               last_t,
    output logic               busy,
    output logic               halted,
    output logic [7:0]         instr_cnt
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [T_WIDTH-1:0] t_q;
    logic [T_WIDTH-1:0] t_next;
    t_idx_t             end_q;
    t_idx_t             live_end;
    logic               hlt_q;
    logic               t_legal;
    logic               in_t3;
    logic               early;
    logic               at_end;
    logic               hlt_eff;

    tstate_end_sel u_end_sel (
        .add_s   (add_s),
        .mul_s   (mul_s),
        .div_s   (div_s),
        .mem_op  (mem_op),
        .end_idx (live_end)
    );

    // Until T3 the end is decided from live flags so a T3-only instruction
    // ends in the right cycle; after T3 only the latched values matter.
    always_comb begin
        t_legal = $onehot(t_q);
        in_t3   = t_q[T_DEF_END];
        early   = |t_q[T_DEF_END:0];
        hlt_eff = in_t3 ? hlt : hlt_q;
        at_end  = 1'b0;
        if (state == ST_EXEC && t_legal) begin
            if (early) begin
                at_end = in_t3 && (live_end == T_DEF_END);
            end else begin
                at_end = |(t_q & t_onehot(end_q));
            end
        end
    end

    // State and T-state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            t_q   <= '0;
        end else begin
            state <= state_next;
            t_q   <= t_next;
        end
    end

    // Freeze end index and halt request at T3; count instructions at their end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_q     <= T_DEF_END;
            hlt_q     <= 1'b0;
            instr_cnt <= 8'd0;
        end else begin
            if (state == ST_EXEC && t_legal && in_t3) begin
                end_q <= live_end;
                hlt_q <= hlt;
            end
            if (at_end) begin
                instr_cnt <= instr_cnt + 8'd1;
            end
        end
    end

    // Next state: start on run/step, advance T-states, decide what follows E.
    always_comb begin
        state_next = state;
        t_next     = '0;
        case (state)
            ST_IDLE: begin
                if (run || step) begin
                    state_next = ST_EXEC;
                    t_next     = T_WIDTH'(1);
                end
            end
            ST_EXEC: begin
                if (!t_legal) begin
                    state_next = ST_IDLE;
                end else if (at_end) begin
                    if (hlt_eff) begin
                        state_next = ST_HALTED;
                    end else if (run) begin
                        state_next = ST_EXEC;
                        t_next     = T_WIDTH'(1);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    t_next = t_q << 1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs: T-vector is shown only when executing with a legal encoding.
    always_comb begin
        t      = (state == ST_EXEC && t_legal) ? t_q : '0;
        busy   = |t;
        last_t = at_end;
        halted = (state == ST_HALTED);
    end

endmodule

// File: tb/tb_tstate_sequencer.sv
// Self-checking bench for tstate_sequencer: a vector table for back-to-back
// execution, plus hand-built sequences for step, halt, reset and count wrap.
module tb_tstate_sequencer;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_ADD  = 5'b00001;
    localparam logic [4:0] F_MEM  = 5'b00010;
    localparam logic [4:0] F_MUL  = 5'b00100;
    localparam logic [4:0] F_DIV  = 5'b01000;
    localparam logic [4:0] F_HLT  = 5'b10000;

    typedef struct {
        logic        run;
        logic        step;
        logic [4:0]  flags;
        logic [11:0] t;
        logic        last_t;
        logic        busy;
        logic        halted;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] t;
        logic        last_t;
        logic        busy;
        logic        halted;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        add_s;
    logic        mul_s;
    logic        div_s;
    logic        mem_op;
    logic        hlt;
    logic [11:0] t;
    logic        last_t;
    logic        busy;
    logic        halted;
    logic [7:0]  instr_cnt;

    int   total;
    int   bad;
    exp_t exp_q[$];
    vec_t tbl[$];

    tstate_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .add_s     (add_s),
        .mul_s     (mul_s),
        .div_s     (div_s),
        .mem_op    (mem_op),
        .hlt       (hlt),
        .t         (t),
        .last_t    (last_t),
        .busy      (busy),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [4:0] f,
                                input logic [11:0] et, input logic el,
                                input logic eh, input logic [7:0] ec);
        vec_t v;
        v.run    = r;
        v.step   = s;
        v.flags  = f;
        v.t      = et;
        v.last_t = el;
        v.busy   = (et != 12'h000);
        v.halted = eh;
        v.cnt    = ec;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic compareAll(input exp_t e);
        cmp({e.name, ".t"}, t, e.t);
        cmp({e.name, ".last_t"}, 12'(last_t), 12'(e.last_t));
        cmp({e.name, ".busy"}, 12'(busy), 12'(e.busy));
        cmp({e.name, ".halted"}, 12'(halted), 12'(e.halted));
        cmp({e.name, ".instr_cnt"}, 12'(instr_cnt), 12'(e.cnt));
    endtask

    // Drive one cycle's inputs just after the clock edge and queue its expectation.
    task automatic applyStimulus(input vec_t v, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        run    = v.run;
        step   = v.step;
        add_s  = v.flags[0];
        mem_op = v.flags[1];
        mul_s  = v.flags[2];
        div_s  = v.flags[3];
        hlt    = v.flags[4];
        e.name   = nm;
        e.t      = v.t;
        e.last_t = v.last_t;
        e.busy   = v.busy;
        e.halted = v.halted;
        e.cnt    = v.cnt;
        exp_q.push_back(e);
    endtask

    // Sample on the falling edge and compare against the oldest expectation.
    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
        end else begin
            e = exp_q.pop_front();
            compareAll(e);
        end
    endtask

    task automatic cycle(input vec_t v, input string nm);
        applyStimulus(v, nm);
        checkOutput();
    endtask

    task automatic resetCheck(input string nm);
        exp_t e;
        e.name   = nm;
        e.t      = 12'h000;
        e.last_t = 1'b0;
        e.busy   = 1'b0;
        e.halted = 1'b0;
        e.cnt    = 8'd0;
        compareAll(e);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        step   = 1'b0;
        add_s  = 1'b0;
        mul_s  = 1'b0;
        div_s  = 1'b0;
        mem_op = 1'b0;
        hlt    = 1'b0;

        #1;
        resetCheck("reset_initial");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: default, mem then add, div+mul with div dropped at T5.
        tbl.push_back(mk(1, 0, F_NONE, 12'h000, 0, 0, 8'd0));
        tbl.push_back(mk(1, 0, F_NONE, 12'h001, 0, 0, 8'd0));
        tbl.push_back(mk(1, 0, F_NONE, 12'h002, 0, 0, 8'd0));
        tbl.push_back(mk(1, 0, F_NONE, 12'h004, 0, 0, 8'd0));
        tbl.push_back(mk(1, 0, F_NONE, 12'h008, 1, 0, 8'd0));
        tbl.push_back(mk(1, 0, F_NONE, 12'h001, 0, 0, 8'd1));
        tbl.push_back(mk(1, 0, F_NONE, 12'h002, 0, 0, 8'd1));
        tbl.push_back(mk(1, 0, F_NONE, 12'h004, 0, 0, 8'd1));
        tbl.push_back(mk(1, 0, F_MEM,  12'h008, 0, 0, 8'd1));
        tbl.push_back(mk(1, 0, F_NONE, 12'h010, 0, 0, 8'd1));
        tbl.push_back(mk(1, 0, F_NONE, 12'h020, 1, 0, 8'd1));
        tbl.push_back(mk(1, 0, F_NONE, 12'h001, 0, 0, 8'd2));
        tbl.push_back(mk(1, 0, F_NONE, 12'h002, 0, 0, 8'd2));
        tbl.push_back(mk(1, 0, F_NONE, 12'h004, 0, 0, 8'd2));
        tbl.push_back(mk(1, 0, F_ADD,  12'h008, 0, 0, 8'd2));
        tbl.push_back(mk(1, 0, F_NONE, 12'h010, 1, 0, 8'd2));
        tbl.push_back(mk(0, 0, F_NONE, 12'h001, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h002, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h004, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_DIV | F_MUL, 12'h008, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_DIV | F_MUL, 12'h010, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_MUL,  12'h020, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h040, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h080, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h100, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h200, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h400, 0, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h800, 1, 0, 8'd3));
        tbl.push_back(mk(0, 0, F_NONE, 12'h000, 0, 0, 8'd4));
        tbl.push_back(mk(0, 0, F_NONE, 12'h000, 0, 0, 8'd4));
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Single step of a multiply; a second step at T4 must be dropped.
        cycle(mk(0, 1, F_MUL, 12'h000, 0, 0, 8'd4), "step_idle");
        for (int k = 0; k <= 10; k++) begin
            cycle(mk(0, (k == 4), F_MUL, 12'h001 << k, (k == 10), 0, 8'd4),
                  $sformatf("step_T%0d", k));
        end
        cycle(mk(0, 0, F_NONE, 12'h000, 0, 0, 8'd5), "step_done0");
        cycle(mk(0, 0, F_NONE, 12'h000, 0, 0, 8'd5), "step_done1");

        // Halt after an add; run and step are ignored afterwards.
        cycle(mk(0, 1, F_ADD | F_HLT, 12'h000, 0, 0, 8'd5), "halt_idle");
        for (int k = 0; k <= 4; k++) begin
            cycle(mk(0, 0, F_ADD | F_HLT, 12'h001 << k, (k == 4), 0, 8'd5),
                  $sformatf("halt_T%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            cycle(mk(1, k[0], F_NONE, 12'h000, 0, 1, 8'd6), $sformatf("halted[%0d]", k));
        end
        #1;
        run   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        #1;
        resetCheck("reset_from_halt");
        @(negedge clk);
        rst_n = 1'b1;

        // Divide interrupted by reset at T7.
        cycle(mk(1, 0, F_DIV, 12'h000, 0, 0, 8'd0), "div_idle");
        for (int k = 0; k <= 7; k++) begin
            cycle(mk(1, 0, F_DIV, 12'h001 << k, 0, 0, 8'd0), $sformatf("div_T%0d", k));
        end
        #1;
        rst_n = 1'b0;
        #1;
        resetCheck("reset_at_T7");
        run   = 1'b0;
        div_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 256 default instructions: counter must reach 255 then wrap to 0.
        cycle(mk(1, 0, F_NONE, 12'h000, 0, 0, 8'd0), "wrap_idle");
        for (int n = 0; n < 256; n++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(mk(!(n == 255 && k == 3), 0, F_NONE, 12'h001 << k, (k == 3), 0, 8'(n)),
                      $sformatf("wrap_n%0d_T%0d", n, k));
            end
        end
        cycle(mk(0, 0, F_NONE, 12'h000, 0, 0, 8'd0), "wrap_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
